sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester and the EXE-stage data requester.
- Sits between the IF/EXE stages and the AXI bridge.
- Grants one request per handshake and holds the grant stable until `addr_ok`.
- Records the source of each accepted request in an in-order ID FIFO, so each `data_ok`/`rdata` returns to the correct requester.

Parameters:
- MAX_OUTST, 4: maximum accepted-but-unanswered requests; power of two, 2..8.
- CNT_W, 3: outstanding-counter width, equal to log2(MAX_OUTST)+1.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- inst_sram_req, data_sram_req  in  1 each  requester request valid
- inst_sram_wr, data_sram_wr  in  1 each  1 = write
- inst_sram_size, data_sram_size  in  2 each  0 = byte, 1 = half, 2 = word
- inst_sram_wstrb, data_sram_wstrb  in  4 each  byte write strobes
- inst_sram_addr, data_sram_addr  in  32 each  physical address
- inst_sram_wdata, data_sram_wdata  in  32 each  write data
- inst_sram_addr_ok, data_sram_addr_ok  out  1 each  request accepted this cycle
- inst_sram_data_ok, data_sram_data_ok  out  1 each  response for this requester
- inst_sram_rdata, data_sram_rdata  out  32 each  read data, 0 when data_ok = 0
- m_req  out  1  downstream request
- m_wr, m_size, m_wstrb, m_addr, m_wdata  out  1/2/4/32/32  muxed request fields
- m_addr_ok  in  1  downstream accepted
- m_data_ok  in  1  downstream response, strictly in order
- m_rdata  in  32  downstream read data
- busy  out  1  outstanding count != 0

Behaviour:
- Reset (async, resetn = 0):
  - Lock, ID FIFO, pointers and outstanding count are cleared.
  - All outputs are 0: `m_req` and `m_*` fields, both `addr_ok`, both `data_ok`, both `rdata`, `busy`.
- Arbitration (combinational select, registered lock):
  - If `lock_valid`, select `lock_id`.
  - Otherwise, select data if `data_sram_req`, else inst if `inst_sram_req`. Data has fixed priority.
- Issue:
  - `full = (count == MAX_OUTST)`.
  - `m_req = selected req & ~full`; `m_*` fields come from the selected requester.
  - Only the selected requester sees `addr_ok = m_addr_ok & m_req`. The other requester's `addr_ok` stays 0.
- Lock:
  - If `m_req & ~m_addr_ok`, set `lock_valid <= 1` and `lock_id <= sel` at the next edge.
  - Clear the lock on the handshake `m_req & m_addr_ok`.
  - A locked requester must hold its request; the arbiter does not re-arbitrate.
- Handshake (`m_req & m_addr_ok`): push `sel` (0 = inst, 1 = data) into the ID FIFO.
- Response (`m_data_ok`):
  - Pop the head of the ID FIFO.
  - Drive `<head>_data_ok = 1` and `<head>_rdata = m_rdata` in the same cycle, with zero latency.
  - Writes also receive `data_ok`.
- Outstanding count: +1 on push, -1 on pop; a push and a pop in the same cycle leave it unchanged. Pointers wrap modulo MAX_OUTST.
- Full:
  - When `count == MAX_OUTST`, `m_req` is forced to 0, even if a pop occurs in the same cycle (the block does not look ahead).
  - A lock held while full persists until the handshake.
- Empty: `m_data_ok` arriving with count == 0 is a protocol error. Both `data_ok` stay 0, the count stays 0, and an assertion fires in simulation.
- Back-to-back: a new handshake is allowed in the cycle after a previous one, for either requester.

Optional Feature:
- ARB_RR_EN
  - Defined: round-robin arbitration. A registered `last_id` is updated on each handshake. When both requests are pending and unlocked, grant `~last_id`. Reset value of `last_id` is 0 (inst), so data wins the first tie.
  - Undefined: fixed data-over-inst priority, and no `last_id` flop exists.
  - Lock, FIFO and full behaviour are identical in both builds.

Test Plan:
- Single inst read: inst_req = 1, addr = 0x1C000000, m_addr_ok = 1 in the same cycle → inst_addr_ok = 1. Two cycles later m_data_ok = 1, m_rdata = 0x02C00000 → inst_data_ok = 1, inst_rdata = 0x02C00000, data_data_ok = 0.
- Simultaneous requests: both req = 1, m_addr_ok = 1 → data granted first, inst granted next cycle. Responses 0xAAAA0001 then 0xBBBB0002 route to data then inst. With ARB_RR_EN the order is the same on the first tie; on a second tie inst wins.
- Lock hold: data store, addr = 0x00000010, wstrb = 0xF, m_addr_ok = 0 for 3 cycles while inst_req = 1 → m_addr stays 0x00000010, inst_addr_ok stays 0. Accept on cycle 4, then inst is issued.
- Full: MAX_OUTST = 4. Four inst reads accepted with no data_ok → count = 4, m_req = 0, busy = 1. A data_ok in the next cycle still leaves m_req = 0. In the following cycle m_req = 1.
- Interleaved: issue inst, data, inst. Three data_ok pulses return 0x11, 0x22, 0x33 → inst gets 0x11, data gets 0x22, inst gets 0x33. Count returns to 0 and busy = 0.
- Reset mid-flight: with 2 outstanding and lock set, pull resetn low asynchronously → all outputs 0 immediately. After release, a new inst read completes normally with count = 1 then 0.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Two-requester (inst fetch / EXE data) arbiter onto one SRAM-like port, with an in-order ID FIFO
// steering responses back. Define ARB_RR_EN for round-robin on ties instead of fixed data priority.
module sram_port_arbiter #(
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  localparam int   PTR_W   = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  logic                 lock_valid_q, lock_valid_d;
  logic                 lock_id_q, lock_id_d;
  logic [MAX_OUTST-1:0] fifo_q, fifo_d;
  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic sel, sel_req, full, push, pop, head;

`ifdef ARB_RR_EN
  logic last_id_q, last_id_d;
`endif

  assign full = (cnt_q == CNT_W'(MAX_OUTST));

  always_comb begin
    sel = ID_INST;
    if (lock_valid_q) begin
      sel = lock_id_q;
`ifdef ARB_RR_EN
    end else if (data_sram_req && inst_sram_req) begin
      sel = ~last_id_q;
`endif
    end else if (data_sram_req) begin
      sel = ID_DATA;
    end
  end

  assign sel_req = (sel == ID_DATA) ? data_sram_req : inst_sram_req;

  // Outputs are gated by resetn so they read 0 for the whole reset window, not only after an edge.
  assign m_req   = resetn & sel_req & ~full;
  assign m_wr    = resetn & ((sel == ID_DATA) ? data_sram_wr : inst_sram_wr);
  assign m_size  = resetn ? ((sel == ID_DATA) ? data_sram_size  : inst_sram_size)  : 2'd0;
  assign m_wstrb = resetn ? ((sel == ID_DATA) ? data_sram_wstrb : inst_sram_wstrb) : 4'd0;
  assign m_addr  = resetn ? ((sel == ID_DATA) ? data_sram_addr  : inst_sram_addr)  : 32'd0;
  assign m_wdata = resetn ? ((sel == ID_DATA) ? data_sram_wdata : inst_sram_wdata) : 32'd0;

  assign push = m_req & m_addr_ok;
  assign pop  = resetn & m_data_ok & (cnt_q != '0);
  assign head = fifo_q[rptr_q];

  assign inst_sram_addr_ok = push & (sel == ID_INST);
  assign data_sram_addr_ok = push & (sel == ID_DATA);
  assign inst_sram_data_ok = pop & (head == ID_INST);
  assign data_sram_data_ok = pop & (head == ID_DATA);
  assign inst_sram_rdata   = inst_sram_data_ok ? m_rdata : 32'd0;
  assign data_sram_rdata   = data_sram_data_ok ? m_rdata : 32'd0;
  assign busy              = resetn & (cnt_q != '0);

  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_id_d    = lock_id_q;
    fifo_d       = fifo_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    cnt_d        = cnt_q;
    // A request stalled by the downstream keeps the grant until it is accepted.
    if (push) begin
      lock_valid_d = 1'b0;
    end else if (m_req) begin
      lock_valid_d = 1'b1;
      lock_id_d    = sel;
    end
    if (push) begin
      fifo_d[wptr_q] = sel;
      wptr_d         = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_valid_q <= 1'b0;
      lock_id_q    <= ID_INST;
      fifo_q       <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
      fifo_q       <= fifo_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cnt_q        <= cnt_d;
    end
  end

`ifdef ARB_RR_EN
  assign last_id_d = push ? sel : last_id_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) last_id_q <= ID_INST;
    else         last_id_q <= last_id_d;
  end
`endif

  // A response with nothing outstanding is a downstream protocol violation.
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!resetn) m_data_ok |-> (cnt_q != '0));

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: reset, routing, priority, lock, full, interleave, mid-flight reset.
module tb_sram_port_arbiter;

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        m_req, m_wr, m_addr_ok, m_data_ok, busy;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.MAX_OUTST(4), .CNT_W(3)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_req), .inst_sram_wr(inst_wr), .inst_sram_size(inst_size),
    .inst_sram_wstrb(inst_wstrb), .inst_sram_addr(inst_addr), .inst_sram_wdata(inst_wdata),
    .inst_sram_addr_ok(inst_addr_ok), .inst_sram_data_ok(inst_data_ok), .inst_sram_rdata(inst_rdata),
    .data_sram_req(data_req), .data_sram_wr(data_wr), .data_sram_size(data_size),
    .data_sram_wstrb(data_wstrb), .data_sram_addr(data_addr), .data_sram_wdata(data_wdata),
    .data_sram_addr_ok(data_addr_ok), .data_sram_data_ok(data_data_ok), .data_sram_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
  endtask

  // Drive one cycle of requests at the falling edge, settle, then let the caller check.
  task automatic drv(input bit ir, input logic [31:0] ia, input bit dr, input logic [31:0] da, input bit aok);
    @(negedge clk);
    clr();
    inst_req = ir; inst_addr = ia; data_req = dr; data_addr = da; m_addr_ok = aok;
    #1;
  endtask

  task automatic quiet();
    @(negedge clk);
    clr();
    #1;
  endtask

  task automatic resp(input string tag, input logic [31:0] rd, input bit to_data);
    @(negedge clk);
    clr();
    m_data_ok = 1; m_rdata = rd;
    #1;
    chk({tag, ".inst_dok"}, inst_data_ok, !to_data);
    chk({tag, ".data_dok"}, data_data_ok, to_data);
    chk({tag, ".rdata"}, to_data ? data_rdata : inst_rdata, rd);
    chk({tag, ".other_rdata"}, to_data ? inst_rdata : data_rdata, 32'd0);
  endtask

  initial begin
    clr();
    resetn = 0;
    inst_req = 1; inst_addr = 32'h1234; m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'hFFFF_FFFF;
    #3;
    chk("rst.m_req", m_req, 0);
    chk("rst.m_addr", m_addr, 0);
    chk("rst.inst_aok", inst_addr_ok, 0);
    chk("rst.inst_dok", inst_data_ok, 0);
    chk("rst.inst_rdata", inst_rdata, 0);
    chk("rst.busy", busy, 0);
    @(negedge clk);
    clr();
    resetn = 1;

    // single inst read
    drv(1, 32'h1C00_0000, 0, 0, 1);
    chk("t1.m_req", m_req, 1);
    chk("t1.m_addr", m_addr, 32'h1C00_0000);
    chk("t1.inst_aok", inst_addr_ok, 1);
    chk("t1.data_aok", data_addr_ok, 0);
    quiet();
    chk("t1.busy", busy, 1);
    resp("t1.r", 32'h02C0_0000, 0);
    quiet();
    chk("t1.idle", busy, 0);

    // ties: data first; on the second tie round-robin hands inst the grant
    drv(1, 32'h100, 1, 32'hD0, 1);
    chk("t2.c1.data_aok", data_addr_ok, 1);
    chk("t2.c1.inst_aok", inst_addr_ok, 0);
    chk("t2.c1.m_addr", m_addr, 32'hD0);
    drv(1, 32'h100, 1, 32'hD4, 1);
    chk("t2.c2.data_aok", data_addr_ok, !RR);
    chk("t2.c2.inst_aok", inst_addr_ok, RR);
    chk("t2.c2.m_addr", m_addr, RR ? 32'h100 : 32'hD4);
    drv(!RR, 32'h100, RR, 32'hD4, 1);
    chk("t2.c3.data_aok", data_addr_ok, RR);
    chk("t2.c3.inst_aok", inst_addr_ok, !RR);
    chk("t2.c3.m_addr", m_addr, RR ? 32'hD4 : 32'h100);
    quiet();
    resp("t2.r1", 32'hAAAA_0001, 1);
    resp("t2.r2", 32'hBBBB_0002, !RR);
    resp("t2.r3", 32'hCCCC_0003, RR);
    quiet();
    chk("t2.idle", busy, 0);

    // data store stalled three cycles while inst waits
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      clr();
      data_req = 1; data_wr = 1; data_wstrb = 4'hF; data_addr = 32'h10; data_wdata = 32'hCAFE_F00D;
      inst_req = 1; inst_addr = 32'h200; m_addr_ok = (i == 3);
      #1;
      chk($sformatf("t3.c%0d.m_addr", i), m_addr, 32'h10);
      chk($sformatf("t3.c%0d.inst_aok", i), inst_addr_ok, 0);
      chk($sformatf("t3.c%0d.data_aok", i), data_addr_ok, (i == 3));
    end
    chk("t3.m_wr", m_wr, 1);
    chk("t3.m_wstrb", m_wstrb, 4'hF);
    chk("t3.m_wdata", m_wdata, 32'hCAFE_F00D);
    drv(1, 32'h200, 0, 0, 1);
    chk("t3.inst_aok", inst_addr_ok, 1);
    chk("t3.inst_addr", m_addr, 32'h200);
    resp("t3.r1", 32'h0, 1);
    resp("t3.r2", 32'h1357, 0);

    // stalled inst keeps the grant even after data shows up
    drv(1, 32'h300, 0, 0, 0);
    chk("t3b.c1.m_req", m_req, 1);
    drv(1, 32'h300, 1, 32'h40, 1);
    chk("t3b.c2.m_addr", m_addr, 32'h300);
    chk("t3b.c2.inst_aok", inst_addr_ok, 1);
    chk("t3b.c2.data_aok", data_addr_ok, 0);
    drv(0, 0, 1, 32'h40, 1);
    chk("t3b.c3.data_aok", data_addr_ok, 1);
    resp("t3b.r1", 32'h2468, 0);
    resp("t3b.r2", 32'h369C, 1);
    quiet();
    chk("t3b.idle", busy, 0);

    // full: four accepted, fifth blocked even with a pop that cycle
    for (int i = 0; i < 4; i++) begin
      drv(1, 32'h400 + 4 * i, 0, 0, 1);
      chk($sformatf("t4.c%0d.inst_aok", i), inst_addr_ok, 1);
    end
    @(negedge clk);
    clr();
    inst_req = 1; inst_addr = 32'h410; m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h55;
    #1;
    chk("t4.full.m_req", m_req, 0);
    chk("t4.full.inst_aok", inst_addr_ok, 0);
    chk("t4.full.busy", busy, 1);
    chk("t4.full.inst_dok", inst_data_ok, 1);
    drv(1, 32'h410, 0, 0, 1);
    chk("t4.after.m_req", m_req, 1);
    chk("t4.after.inst_aok", inst_addr_ok, 1);
    for (int i = 0; i < 4; i++) resp($sformatf("t4.r%0d", i), 32'h60 + i, 0);
    quiet();
    chk("t4.idle", busy, 0);

    // interleaved inst/data/inst
    drv(1, 32'h500, 0, 0, 1);
    chk("t5.c1.inst_aok", inst_addr_ok, 1);
    drv(0, 0, 1, 32'h504, 1);
    chk("t5.c2.data_aok", data_addr_ok, 1);
    drv(1, 32'h508, 0, 0, 1);
    chk("t5.c3.inst_aok", inst_addr_ok, 1);
    resp("t5.r1", 32'h11, 0);
    resp("t5.r2", 32'h22, 1);
    resp("t5.r3", 32'h33, 0);
    quiet();
    chk("t5.idle", busy, 0);

    // reset with two outstanding and a lock held
    drv(1, 32'h600, 0, 0, 1);
    drv(0, 0, 1, 32'h604, 1);
    drv(1, 32'h608, 0, 0, 0);
    @(negedge clk);
    clr();
    inst_req = 1; inst_addr = 32'h608;
    #1;
    chk("t6.pre.m_req", m_req, 1);
    chk("t6.pre.busy", busy, 1);
    #2;
    resetn = 0;
    m_data_ok = 1; m_rdata = 32'h99;
    #1;
    chk("t6.rst.m_req", m_req, 0);
    chk("t6.rst.m_addr", m_addr, 0);
    chk("t6.rst.busy", busy, 0);
    chk("t6.rst.inst_dok", inst_data_ok, 0);
    chk("t6.rst.data_dok", data_data_ok, 0);
    @(negedge clk);
    clr();
    resetn = 1;
    drv(0, 0, 1, 32'h700, 1);
    chk("t6.nolock.data_aok", data_addr_ok, 1);
    resp("t6.r0", 32'h70, 1);
    drv(1, 32'h704, 0, 0, 1);
    chk("t6.inst_aok", inst_addr_ok, 1);
    quiet();
    chk("t6.busy1", busy, 1);
    resp("t6.r1", 32'h77, 0);
    quiet();
    chk("t6.idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
